// File: rtl/idli_sqi_rx_m.sv
// rtl/idli_sqi_rx_m.sv - SQI read data-phase receiver: nibble assembly into 16-bit words plus output FIFO
//
// Two memories share the read: MEM0 supplies the high nibble of each byte and
// MEM1 the low nibble, half an SCK later. Nibbles therefore alternate lanes
// MEM0, MEM1, MEM0, MEM1 and four of them make one 16-bit word.
//
// Parameters:
//   DEPTH        output FIFO entries, power of two, >= 2
// Ports:
//   i_sqi_gck    clock, all flops on the rising edge
//   i_sqi_rst_n  asynchronous active-low reset
//   i_rx_start   pulse: data phase begins, first MEM0 nibble valid on the next edge
//   i_rx_stop    pulse: data phase ends, any partial word is discarded
//   i_sqi_sio    nibble inputs, [0] = MEM0 (high nibbles), [1] = MEM1 (low nibbles)
//   o_rx_data    head FIFO word (holds the last popped word while empty)
//   o_rx_valid   head word valid
//   i_rx_ready   consumer accepts the head word when valid
//   o_rx_busy    high while in the DATA state
//   o_rx_ovf     sticky overflow flag
// Configuration:
//   IDLI_SQI_RX_OVF_EN  when defined, o_rx_ovf is set on a dropped word and held
//                       until reset or the next accepted start; otherwise tied 0

module idli_sqi_rx_m #(
    parameter  int DEPTH   = 2,
    localparam int SQI_NUM = 2,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic                    i_sqi_gck,
    input  logic                    i_sqi_rst_n,
    input  logic                    i_rx_start,
    input  logic                    i_rx_stop,
    input  logic [SQI_NUM-1:0][3:0] i_sqi_sio,
    output logic [15:0]             o_rx_data,
    output logic                    o_rx_valid,
    input  logic                    i_rx_ready,
    output logic                    o_rx_busy,
    output logic                    o_rx_ovf
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    nib_q, nib_d;
    logic [11:0]   word_q, word_d;
    logic [3:0]    nib_cur;
    logic          push;
    logic [15:0]   push_word;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_idx;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          pop;
    logic          wr_en;

    // Even nibbles come from MEM0, odd nibbles from MEM1.
    assign nib_cur   = i_sqi_sio[nib_q[0]];
    assign push_word = {word_q, nib_cur};

    // ------------------------------------------------------------------
    // Data-phase FSM and nibble assembly
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        nib_d   = nib_q;
        word_d  = word_q;
        push    = 1'b0;
        if (i_rx_stop) begin
            // Stop wins over a simultaneous start.
            state_d = ST_IDLE;
            nib_d   = 2'd0;
        end else if (i_rx_start) begin
            // Start (or restart) edge does not sample; the partial word is
            // abandoned simply by clearing the nibble counter.
            state_d = ST_DATA;
            nib_d   = 2'd0;
        end else if (state_q == ST_DATA) begin
            nib_d  = nib_q + 2'd1;
            word_d = {word_q[7:0], nib_cur};
            push   = (nib_q == 2'd3);
        end
    end

    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            state_q <= ST_IDLE;
            nib_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            nib_q   <= nib_d;
        end
    end

    // The shift register only ever holds nibbles collected since the last
    // start, so it needs no reset.
    always_ff @(posedge i_sqi_gck) begin
        word_q <= word_d;
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    assign full       = (count_q == CW'(DEPTH));
    assign o_rx_valid = (count_q != '0);
    assign pop        = o_rx_valid && i_rx_ready;
    // A pop frees a slot in the same edge, so a push into a full FIFO with a
    // concurrent pop still lands. Without a pop the word is lost because the
    // memories cannot be stalled.
    assign wr_en      = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_sqi_gck) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    // When empty, point one slot back so the output shows the last word
    // popped; that slot cannot have been rewritten while the FIFO is empty.
    assign rd_idx    = o_rx_valid ? rd_ptr_q : (rd_ptr_q - AW'(1));
    assign o_rx_data = mem_q[rd_idx];

    assign o_rx_busy = (state_q == ST_DATA);

    // ------------------------------------------------------------------
    // Overflow flag
    // ------------------------------------------------------------------
`ifdef IDLI_SQI_RX_OVF_EN
    logic ovf_q, ovf_d;
    logic drop;

    assign drop = push && full && !pop;

    always_comb begin
        ovf_d = ovf_q;
        if (i_rx_start && !i_rx_stop) begin
            ovf_d = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_rx_ovf = ovf_q;
`else
    assign o_rx_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_idli_sqi_rx_m.sv
// tb/tb_idli_sqi_rx_m.sv - self-checking bench for idli_sqi_rx_m with a queue-based reference model

module tb_idli_sqi_rx_m;

    localparam int DEPTH = 2;
`ifdef IDLI_SQI_RX_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            stop;
    logic [1:0][3:0] sio;
    logic [15:0]     rx_data;
    logic            rx_valid;
    logic            ready;
    logic            busy;
    logic            ovf;

    int checks = 0;
    int errors = 0;

    // Reference model state: collected nibbles, queued words, phase flag.
    bit          m_active;
    logic [3:0]  m_nibs[$];
    logic [15:0] m_q[$];
    bit          m_ovf;

    idli_sqi_rx_m #(.DEPTH(DEPTH)) dut (
        .i_sqi_gck   (clk),
        .i_sqi_rst_n (rst_n),
        .i_rx_start  (start),
        .i_rx_stop   (stop),
        .i_sqi_sio   (sio),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .i_rx_ready  (ready),
        .o_rx_busy   (busy),
        .o_rx_ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_nibs.delete();
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    // One clock edge of the specified behaviour, from the inputs present at it.
    task automatic model_step();
        bit          pushw;
        bit          popn;
        logic [15:0] w;
        pushw = 1'b0;
        w     = '0;
        popn  = (m_q.size() != 0) && ready;
        if (stop) begin
            m_active = 1'b0;
            m_nibs.delete();
        end else if (start) begin
            m_active = 1'b1;
            m_nibs.delete();
            m_ovf = 1'b0;
        end else if (m_active) begin
            m_nibs.push_back(sio[m_nibs.size() % 2]);
            if (m_nibs.size() == 4) begin
                w = {m_nibs[0], m_nibs[1], m_nibs[2], m_nibs[3]};
                m_nibs.delete();
                pushw = 1'b1;
            end
        end
        if (popn) void'(m_q.pop_front());
        if (pushw) begin
            if (m_q.size() < DEPTH) m_q.push_back(w);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("valid", 32'(rx_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("data", 32'(rx_data), 32'(m_q[0]));
        chk("busy", 32'(busy), 32'(m_active));
        chk("ovf", 32'(ovf), 32'(OVF_EN && m_ovf));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        check_outputs();
    endtask

    task automatic send_nib(input int lane, input logic [3:0] n);
        sio[lane]     = n;
        sio[1 - lane] = 4'($urandom);
        cycle();
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int k = 0; k < 4; k++) send_nib(k % 2, w[15 - 4*k -: 4]);
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", 32'(rx_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        ready = 1'b0;
        sio   = '0;
        model_reset();

        // Reset state
        repeat (3) cycle();
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Single word ABCD, valid exactly after the fourth nibble edge
        ready = 1'b1;
        do_start();
        chk("start_busy", 32'(busy), 32'd1);
        send_nib(0, 4'hA);
        send_nib(1, 4'hB);
        send_nib(0, 4'hC);
        chk("abcd_early", 32'(rx_valid), 32'd0);
        send_nib(1, 4'hD);
        chk("abcd_valid", 32'(rx_valid), 32'd1);
        chk("abcd_data", 32'(rx_data), 32'h0000ABCD);
        do_stop();

        // Three words into a two-entry FIFO with no consumer
        ready = 1'b0;
        do_start();
        send_word(16'h1234);
        send_word(16'h5678);
        send_word(16'h9ABC);
        do_stop();
        chk("ovf3_head", 32'(rx_data), 32'h00001234);
        chk("ovf3_flag", 32'(ovf), 32'(OVF_EN));
        ready = 1'b1;
        cycle();
        chk("ovf3_second", 32'(rx_data), 32'h00005678);
        cycle();
        chk("ovf3_empty", 32'(rx_valid), 32'd0);
        chk("ovf3_sticky", 32'(ovf), 32'(OVF_EN));

        // Stop two nibbles into the second word
        ready = 1'b0;
        do_start();
        chk("start_clr_ovf", 32'(ovf), 32'd0);
        send_word(16'h2468);
        send_nib(0, 4'h1);
        send_nib(1, 4'h3);
        do_stop();
        chk("stop_busy", 32'(busy), 32'd0);
        repeat (3) cycle();
        ready = 1'b1;
        cycle();
        cycle();
        chk("stop_one_word", 32'(rx_valid), 32'd0);

        // Restart after three nibbles realigns to MEM0
        ready = 1'b0;
        do_start();
        send_nib(0, 4'h7);
        send_nib(1, 4'h7);
        send_nib(0, 4'h7);
        do_start();
        send_word(16'hCAFE);
        do_stop();
        chk("restart_data", 32'(rx_data), 32'h0000CAFE);
        ready = 1'b1;
        cycle();
        chk("restart_single", 32'(rx_valid), 32'd0);

        // Full FIFO, pop and push on the same edge
        ready = 1'b0;
        do_start();
        send_word(16'h1111);
        send_word(16'h2222);
        send_nib(0, 4'h3);
        send_nib(1, 4'h3);
        send_nib(0, 4'h3);
        ready = 1'b1;
        send_nib(1, 4'h3);
        ready = 1'b0;
        chk("full_pp_head", 32'(rx_data), 32'h00002222);
        chk("full_pp_noovf", 32'(ovf), 32'd0);
        do_stop();
        ready = 1'b1;
        cycle();
        chk("full_pp_tail", 32'(rx_data), 32'h00003333);
        cycle();
        chk("full_pp_empty", 32'(rx_valid), 32'd0);
        start = 1'b1;
        stop  = 1'b1;
        cycle();
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-word with words queued
        ready = 1'b0;
        do_start();
        send_word(16'h4444);
        send_word(16'h5555);
        send_word(16'h6666);
        send_nib(0, 4'h8);
        send_nib(1, 4'h8);
        chk("pre_rst_valid", 32'(rx_valid), 32'd1);
        async_reset();
        ready = 1'b1;
        repeat (6) cycle();
        chk("post_rst_quiet", 32'(rx_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            ready = (i < 2000) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
            sio   = 8'($urandom);
            if ($urandom_range(0, 799) == 0) async_reset();
            cycle();
        end

        start = 1'b0;
        stop  = 1'b0;
        ready = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
